// File: rtl/sum_display_driver_if.sv
// Handshake between the adder side and the display driver: the adder
// presents a 5-bit sum and pulses load; the driver reports busy while it
// converts.
interface sum_display_driver_if;
  logic [4:0] sum;
  logic       load;
  logic       busy;

  // Adder side: drives the sum and the capture request.
  modport master (
    output sum,
    output load,
    input  busy
  );

  // Display driver side: samples the sum, reports conversion activity.
  modport slave (
    input  sum,
    input  load,
    output busy
  );
endinterface

// File: rtl/sum_display_driver.sv
// Captures a 5-bit adder sum, converts it to two BCD digits with a
// sequential double-dabble FSM, and scans them onto a 2-digit multiplexed
// 7-segment display with leading-zero blanking. A carry LED lights for
// sums of 16 or more.
module sum_display_driver #(
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  sum_display_driver_if.slave bus,
  output logic [6:0]          seg,
  output logic [1:0]          an,
  output logic                carry_led
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  // Pin-level "off" levels for the selected polarity.
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
  localparam logic [1:0] AN_OFF  = SEG_ACTIVE_LOW ? 2'b11 : 2'b00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one decimal digit.
  function automatic logic [6:0] digit_pattern(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = 7'b1111111;
    endcase
    return p;
  endfunction

  state_t      state;
  logic        busy_q;
  logic [4:0]  shreg;      // captured sum, consumed MSB first
  logic        cap_carry;  // captured sum[4], i.e. sum >= 16
  logic [2:0]  bit_cnt;
  logic [1:0]  acc_tens;   // BCD accumulator; tens never exceeds 3
  logic [3:0]  acc_units;
  logic [3:0]  units_adj;
  logic [1:0]  tens;       // committed display digits
  logic [3:0]  units;

  logic [CNT_W-1:0] refresh_cnt;
  logic             sel_tens;     // 0 = units slot, 1 = tens slot
  logic [6:0]       seg_low;
  logic [1:0]       an_low;

  assign bus.busy = busy_q;

  // Double-dabble correction of the units nibble ahead of each shift. The
  // tens nibble can hold at most 3 for a 5-bit input, so it never needs one.
  assign units_adj = (acc_units >= 4'd5) ? acc_units + 4'd3 : acc_units;

  // Conversion FSM: capture, five shift steps, then commit to the display.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy_q    <= 1'b0;
      shreg     <= '0;
      cap_carry <= 1'b0;
      bit_cnt   <= '0;
      acc_tens  <= '0;
      acc_units <= '0;
      tens      <= '0;
      units     <= '0;
      carry_led <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.load) begin
            shreg     <= bus.sum;
            cap_carry <= bus.sum[4];
            bit_cnt   <= '0;
            acc_tens  <= '0;
            acc_units <= '0;
            busy_q    <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          acc_tens  <= {acc_tens[0], units_adj[3]};
          acc_units <= {units_adj[2:0], shreg[4]};
          shreg     <= {shreg[3:0], 1'b0};
          if (bit_cnt == 3'd4) begin
            state <= UPDATE;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        UPDATE: begin
          tens      <= acc_tens;
          units     <= acc_units;
          carry_led <= cap_carry;
          busy_q    <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Free-running scan timer: toggles the digit slot every REFRESH_DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt <= '0;
      sel_tens    <= 1'b0;
    end else if (refresh_cnt == CNT_LAST) begin
      refresh_cnt <= '0;
      sel_tens    <= ~sel_tens;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // Active-low slot contents, with the tens digit blanked when it is zero.
  // NOTE: defaults first so every path assigns both outputs and no latch is
  // inferred.
  always_comb begin
    an_low  = 2'b10;
    seg_low = digit_pattern(units);
    if (sel_tens) begin
      if (tens == 2'd0) begin
        an_low  = 2'b11;
        seg_low = 7'b1111111;
      end else begin
        an_low  = 2'b01;
        seg_low = digit_pattern({2'b00, tens});
      end
    end
  end

  // Registered display pins, converted to the board polarity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= SEG_OFF;
      an  <= AN_OFF;
    end else begin
      seg <= SEG_ACTIVE_LOW ? seg_low : ~seg_low;
      an  <= SEG_ACTIVE_LOW ? an_low  : ~an_low;
    end
  end

endmodule

// File: tb/tb_sum_display_driver.sv
// Directed bench for sum_display_driver with a 4-cycle scan slot and
// active-low display pins.
module tb_sum_display_driver;

  localparam logic [6:0] P0 = 7'b1000000;
  localparam logic [6:0] P1 = 7'b1111001;
  localparam logic [6:0] P2 = 7'b0100100;
  localparam logic [6:0] P3 = 7'b0110000;
  localparam logic [6:0] P5 = 7'b0010010;
  localparam logic [6:0] P6 = 7'b0000010;
  localparam logic [6:0] P7 = 7'b1111000;
  localparam logic [6:0] P9 = 7'b0010000;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic       clk;
  logic       rst;
  logic [6:0] seg;
  logic [1:0] an;
  logic       carry_led;

  int n_checks;
  int n_errors;

  // Values collected by scan_slots.
  logic [6:0] units_seg;
  logic [1:0] tens_an;
  logic [6:0] tens_seg;

  sum_display_driver_if bus ();

  sum_display_driver #(
    .REFRESH_DIV    (4),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .seg       (seg),
    .an        (an),
    .carry_led (carry_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] actual,
                       input logic [7:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b", tag, actual, expected);
    end
  endtask

  // Pulse load for one edge with the given sum, driven at a falling edge.
  task automatic pulse_load(input logic [4:0] value);
    @(negedge clk);
    bus.sum  = value;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    bus.sum  = 5'h0a;  // later changes on sum must not matter
  endtask

  // Counts falling edges with busy high after a load edge (bounded).
  task automatic count_busy(output int cycles);
    cycles = 0;
    while (bus.busy === 1'b1 && cycles < 20) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  // Watches a full scan period and records what each slot shows.
  task automatic scan_slots();
    units_seg = 'x;
    tens_an   = 'x;
    tens_seg  = 'x;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (an == 2'b10) units_seg = seg;
      else begin
        tens_an  = an;
        tens_seg = seg;
      end
    end
  endtask

  // Full conversion: load, expect 6 busy cycles, then check the display.
  task automatic convert(input string tag, input logic [4:0] value,
                         input logic [1:0] exp_tens_an,
                         input logic [6:0] exp_tens_seg,
                         input logic [6:0] exp_units_seg,
                         input logic exp_carry);
    int cycles;
    pulse_load(value);
    count_busy(cycles);
    check({tag, " busy_cycles"}, 8'(cycles), 8'd6);
    scan_slots();
    check({tag, " units_seg"}, {1'b0, units_seg}, {1'b0, exp_units_seg});
    check({tag, " tens_an"}, {6'b0, tens_an}, {6'b0, exp_tens_an});
    check({tag, " tens_seg"}, {1'b0, tens_seg}, {1'b0, exp_tens_seg});
    check({tag, " carry_led"}, {7'b0, carry_led}, {7'b0, exp_carry});
  endtask

  initial begin
    int cycles;
    n_checks = 0;
    n_errors = 0;
    bus.sum  = '0;
    bus.load = 1'b0;
    rst      = 1'b1;

    // 1. Reset holds the display off across clock edges.
    #2;
    check("rst an", {6'b0, an}, 8'b11);
    check("rst seg", {1'b0, seg}, {1'b0, BLANK});
    repeat (3) @(posedge clk);
    #1;
    check("rst an clocked", {6'b0, an}, 8'b11);
    check("rst seg clocked", {1'b0, seg}, {1'b0, BLANK});
    @(negedge clk);
    rst = 1'b0;
    scan_slots();
    check("post_rst units_seg", {1'b0, units_seg}, {1'b0, P0});
    check("post_rst tens_an", {6'b0, tens_an}, 8'b11);
    check("post_rst tens_seg", {1'b0, tens_seg}, {1'b0, BLANK});
    check("post_rst busy", {7'b0, bus.busy}, 8'd0);
    check("post_rst carry", {7'b0, carry_led}, 8'd0);

    // 2-3. Main conversions.
    convert("sum30", 5'd30, 2'b01, P3, P0, 1'b1);
    convert("sum9", 5'd9, 2'b11, BLANK, P9, 1'b0);

    // 5. A load during busy is dropped; the next one after busy is taken.
    @(negedge clk);
    bus.sum  = 5'd12;
    bus.load = 1'b1;
    @(negedge clk);              // E0 has passed
    bus.load = 1'b0;
    @(negedge clk);
    bus.sum  = 5'd5;
    bus.load = 1'b1;
    check("ignored_load busy", {7'b0, bus.busy}, 8'd1);
    @(negedge clk);
    bus.load = 1'b0;
    cycles = 2;
    while (bus.busy === 1'b1 && cycles < 20) begin
      cycles++;
      @(negedge clk);
    end
    check("ignored_load busy_cycles", 8'(cycles), 8'd6);
    scan_slots();
    check("sum12 units_seg", {1'b0, units_seg}, {1'b0, P2});
    check("sum12 tens_seg", {1'b0, tens_seg}, {1'b0, P1});
    check("sum12 tens_an", {6'b0, tens_an}, 8'b01);
    convert("sum5", 5'd5, 2'b11, BLANK, P5, 1'b0);

    // 4. Boundaries.
    convert("sum15", 5'd15, 2'b01, P1, P5, 1'b0);
    convert("sum31", 5'd31, 2'b01, P3, P1, 1'b1);
    convert("sum16", 5'd16, 2'b01, P1, P6, 1'b1);

    // 6. Asynchronous reset during the third shift cycle.
    @(negedge clk);
    bus.sum  = 5'd27;
    bus.load = 1'b1;
    @(posedge clk);              // E0
    #1 bus.load = 1'b0;
    repeat (3) @(posedge clk);   // E1..E3
    #2 rst = 1'b1;
    #1;
    check("abort busy", {7'b0, bus.busy}, 8'd0);
    check("abort an", {6'b0, an}, 8'b11);
    check("abort seg", {1'b0, seg}, {1'b0, BLANK});
    check("abort carry", {7'b0, carry_led}, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    convert("sum7", 5'd7, 2'b11, BLANK, P7, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time limit in case the run stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sum_display_driver.md
Name: sum_display_driver

Overview:
Downstream consumer of the 4-bit parallel adder: captures the 5-bit sum (s4..s0), converts it to two BCD digits with a sequential double-dabble FSM, and drives a 2-digit multiplexed 7-segment display. Also drives a carry LED for sums of 16 or more. Sits between the adder outputs and the board display pins.

Parameters:
REFRESH_DIV, 50000, clock cycles per digit slot in the scan; must be >= 2; the counter width is clog2(REFRESH_DIV).
SEG_ACTIVE_LOW, 1, 1 = segments and anodes active-low (board default); 0 = both active-high.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
sum  input  5  adder result; sum[4] = s4 (carry), sum[0] = s0
load  input  1  single-cycle request to capture sum
busy  output  1  high while a conversion is in progress; load is ignored while high
seg  output  7  segments {g,f,e,d,c,b,a}; seg[0] = a
an  output  2  digit enables; an[0] = units, an[1] = tens
carry_led  output  1  high when the displayed value is >= 16

Behaviour:
- Clocking: one clock, clk. Reset rst is asynchronous and active-high. Every register clears immediately on rst, independent of clk.
- Reset values (active-low build):
  - busy = 0, carry_led = 0.
  - an = 2'b11 (both digits off), seg = 7'b1111111 (blank).
  - Internal display registers tens = 0, units = 0; refresh counter = 0; digit select = units; FSM = IDLE.
- FSM states:
  - IDLE: wait for load. On the edge E0 where load = 1, capture sum into the shift register, clear the BCD accumulator, go to SHIFT, busy = 1.
  - SHIFT: 5 cycles (edges E1..E5). Each cycle, add 3 to any BCD nibble >= 5, then shift left one bit with the next sum bit, MSB first.
  - UPDATE: edge E6. Commit tens/units to the display registers and set carry_led = (captured sum >= 16). Return to IDLE with busy = 0.
- Timing: busy is high after E0 through E6 (6 cycles). The display registers change on E6.
- Load rules:
  - load while busy is ignored; there is no queueing.
  - load held high in IDLE starts a new capture on every IDLE cycle.
  - sum is sampled only at E0; later changes on sum have no effect on the conversion in progress.
- Range: sum 0..31 gives tens 0..3 and units 0..9. Tens is never > 3.
- Scan:
  - The refresh counter runs continuously, independent of the FSM, counting 0..REFRESH_DIV-1.
  - At the terminal count it wraps to 0 and toggles the digit select.
  - seg and an are registered and update one cycle after the select toggle.
- Digit slots:
  - Units slot: an = 2'b10, seg = pattern(units).
  - Tens slot: an = 2'b01, seg = pattern(tens).
  - Leading-zero blanking: if tens = 0, the tens slot drives an = 2'b11 and seg = blank.
- Segment patterns (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Polarity: when SEG_ACTIVE_LOW = 0, seg and an are bitwise inverted. The blank/off state becomes all zeros.
- Display stability: the display registers change only at commit, so a slot never shows a mix of old and new digits.
- Reset mid-conversion: the conversion aborts, the display returns to reset values, and the next load after rst deasserts converts normally.
- Simultaneous rst and load: rst wins.

Test Plan:
Bench uses REFRESH_DIV = 4 and SEG_ACTIVE_LOW = 1.
1. Reset: with rst high, an = 11 and seg = 1111111 regardless of clk. After release, the units slot shows an = 10, seg = 1000000; the tens slot shows an = 11; busy = 0, carry_led = 0.
2. Load sum = 30: busy is high exactly 6 cycles. After commit, the units slot shows 1000000 (0), the tens slot shows an = 01, seg = 0110000 (3), carry_led = 1.
3. Load sum = 9: tens slot blanked (an = 11), units = 0010000, carry_led = 0.
4. Boundaries: sum = 31 gives tens 3 / units 1 (1111001), carry_led = 1. sum = 16 gives 1 / 6 (0000010), carry_led = 1. sum = 15 gives 1 / 5, carry_led = 0.
5. Load sum = 12, then pulse load with sum = 5 two cycles later (busy high): the second load is ignored and the display settles at 1 / 2. A load after busy falls is accepted.
6. Assert rst at the third SHIFT cycle of a sum = 27 conversion: busy, an, seg and carry_led return to reset values immediately. After release, load sum = 7 displays a blank tens slot and units 1111000.
